// File: rtl/axis_slave_rx.sv
`default_nettype none
// ============================================================================
// Module   : axis_slave_rx
// Brief    : AXI-Stream slave receiver. Incoming beats go into a show-ahead
//            FIFO. Packet and byte statistics are kept alongside, together
//            with a sticky flag for malformed tkeep patterns.
// Revision : 1.0 - initial release
// ============================================================================
module axis_slave_rx #(
    parameter int TDATA_BYTES = 4,
    parameter int DEPTH       = 16
) (
    input  logic                         aclk,
    input  logic                         aresetn,
    input  logic                         s_tvalid,
    output logic                         s_tready,
    input  logic [TDATA_BYTES*8-1:0]     s_tdata,
    input  logic [TDATA_BYTES-1:0]       s_tkeep,
    input  logic                         s_tlast,
    input  logic [TDATA_BYTES-1:0]       s_tstrb,
    input  logic [7:0]                   s_tid,
    input  logic [3:0]                   s_tdest,
    input  logic [0:0]                   s_tuser,
    output logic [TDATA_BYTES*8-1:0]     out_data,
    output logic [TDATA_BYTES-1:0]       out_keep,
    output logic                         out_last,
    output logic                         out_empty,
    input  logic                         out_pop,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic [15:0]                  pkt_count,
    output logic [15:0]                  last_pkt_bytes,
    output logic                         keep_err,
    input  logic                         err_clr
);

    localparam int c_dw = TDATA_BYTES * 8;
    localparam int c_aw = $clog2(DEPTH);
    localparam int c_lw = $clog2(DEPTH + 1);
    localparam int c_ew = c_dw + TDATA_BYTES + 1;

    localparam logic [c_lw-1:0]        c_full     = c_lw'(DEPTH);
    localparam logic [c_lw-1:0]        c_lvl_one  = c_lw'(1);
    localparam logic [c_aw-1:0]        c_ptr_one  = c_aw'(1);
    localparam logic [TDATA_BYTES-1:0] c_keep_one = TDATA_BYTES'(1);

    logic [1:0]            rst_sync_q;
    logic [c_ew-1:0]       mem_q [DEPTH];
    logic [c_aw-1:0]       wr_ptr_q, wr_ptr_d;
    logic [c_aw-1:0]       rd_ptr_q, rd_ptr_d;
    logic [c_lw-1:0]       level_q, level_d;
    logic [15:0]           acc_q, acc_d;
    logic [15:0]           last_bytes_q, last_bytes_d;
    logic [15:0]           pkt_q, pkt_d;
    logic                  err_q, err_d;

    logic                  w_accept;
    logic                  w_pop;
    logic                  w_empty;
    logic [c_ew-1:0]       w_head;
    logic [16:0]           w_sum;
    logic [15:0]           w_sum_sat;
    logic [TDATA_BYTES-1:0] w_keep_inc;
    logic                  w_keep_full;
    logic                  w_keep_contig;
    logic                  w_keep_bad;
    logic                  w_unused_ok;

    function automatic logic [16:0] popcnt(input logic [TDATA_BYTES-1:0] k);
        logic [16:0] n;
        n = '0;
        for (int i = 0; i < TDATA_BYTES; i++) begin
            n = n + 17'(k[i]);
        end
        return n;
    endfunction

    // Reset asserts asynchronously; release is re-timed so ready comes up cleanly.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign w_empty   = (level_q == '0);
    assign s_tready  = rst_sync_q[1] && (level_q != c_full);
    assign w_accept  = s_tvalid && s_tready;
    assign w_pop     = out_pop && !w_empty;

    always_ff @(posedge aclk) begin
        if (w_accept) begin
            mem_q[wr_ptr_q] <= {s_tdata, s_tkeep, s_tlast};
        end
    end

    assign w_head    = mem_q[rd_ptr_q];
    assign out_data  = w_head[c_ew-1 -: c_dw];
    assign out_keep  = w_head[TDATA_BYTES:1];
    assign out_last  = w_head[0];
    assign out_empty = w_empty;

    assign w_sum     = {1'b0, acc_q} + popcnt(s_tkeep);
    assign w_sum_sat = w_sum[16] ? 16'hFFFF : w_sum[15:0];

    // A legal last beat keeps a contiguous run of low bytes: 2^n-1, n >= 1.
    assign w_keep_inc    = s_tkeep + c_keep_one;
    assign w_keep_full   = &s_tkeep;
    assign w_keep_contig = (s_tkeep != '0) && ((s_tkeep & w_keep_inc) == '0);
    assign w_keep_bad    = w_accept && (s_tlast ? !w_keep_contig : !w_keep_full);

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        level_d      = level_q;
        acc_d        = acc_q;
        last_bytes_d = last_bytes_q;
        pkt_d        = pkt_q;
        err_d        = err_q;

        if (w_accept) begin
            wr_ptr_d = wr_ptr_q + c_ptr_one;
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + c_ptr_one;
        end
        if (w_accept && !w_pop) begin
            level_d = level_q + c_lvl_one;
        end else if (!w_accept && w_pop) begin
            level_d = level_q - c_lvl_one;
        end

        if (w_accept) begin
            if (s_tlast) begin
                acc_d        = '0;
                last_bytes_d = w_sum_sat;
                pkt_d        = pkt_q + 16'd1;
            end else begin
                acc_d        = w_sum_sat;
            end
        end

        // A fresh violation outranks a clear request in the same cycle.
        if (w_keep_bad) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            acc_q        <= '0;
            last_bytes_q <= '0;
            pkt_q        <= '0;
            err_q        <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            acc_q        <= acc_d;
            last_bytes_q <= last_bytes_d;
            pkt_q        <= pkt_d;
            err_q        <= err_d;
        end
    end

    assign level          = level_q;
    assign pkt_count      = pkt_q;
    assign last_pkt_bytes = last_bytes_q;
    assign keep_err       = err_q;

    // Sideband fields are accepted on the bus but carry no meaning here.
    assign w_unused_ok = ^{s_tstrb, s_tid, s_tdest, s_tuser};

endmodule
`default_nettype wire

// File: tb/tb_axis_slave_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_axis_slave_rx
// Brief    : Self-checking bench for axis_slave_rx with a FIFO scoreboard and
//            a reference model of the packet statistics.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axis_slave_rx;

    localparam int TB    = 4;
    localparam int DEPTH = 16;

    logic              aclk = 1'b0;
    logic              aresetn;
    logic              s_tvalid;
    logic              s_tready;
    logic [TB*8-1:0]   s_tdata;
    logic [TB-1:0]     s_tkeep;
    logic              s_tlast;
    logic [TB-1:0]     s_tstrb;
    logic [7:0]        s_tid;
    logic [3:0]        s_tdest;
    logic [0:0]        s_tuser;
    logic [TB*8-1:0]   out_data;
    logic [TB-1:0]     out_keep;
    logic              out_last;
    logic              out_empty;
    logic              out_pop;
    logic [4:0]        level;
    logic [15:0]       pkt_count;
    logic [15:0]       last_pkt_bytes;
    logic              keep_err;
    logic              err_clr;

    typedef logic [TB*8+TB:0] ent_t;

    ent_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [15:0] m_pkt, m_last, m_acc;
    logic        m_err;
    logic        st_acc, st_popped;
    ent_t        st_got, st_exp;

    always #5 aclk = ~aclk;

    axis_slave_rx #(.TDATA_BYTES(TB), .DEPTH(DEPTH)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_tvalid(s_tvalid), .s_tready(s_tready),
        .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tlast(s_tlast),
        .s_tstrb(s_tstrb), .s_tid(s_tid), .s_tdest(s_tdest), .s_tuser(s_tuser),
        .out_data(out_data), .out_keep(out_keep), .out_last(out_last),
        .out_empty(out_empty), .out_pop(out_pop), .level(level),
        .pkt_count(pkt_count), .last_pkt_bytes(last_pkt_bytes),
        .keep_err(keep_err), .err_clr(err_clr)
    );

    function automatic void model_clear();
        sb.delete();
        m_pkt  = '0;
        m_last = '0;
        m_acc  = '0;
        m_err  = 1'b0;
    endfunction

    // One clock of stimulus; records acceptance and the head seen on a pop.
    task automatic step(input logic v, input logic [31:0] d, input logic [3:0] k,
                        input logic l, input logic p, input logic clr);
        int  sum;
        logic bad;
        @(negedge aclk);
        s_tvalid = v; s_tdata = d; s_tkeep = k; s_tlast = l;
        out_pop = p; err_clr = clr;
        s_tstrb = 4'($urandom); s_tid = 8'($urandom);
        s_tdest = 4'($urandom); s_tuser = 1'($urandom);
        #1;
        st_acc    = v && s_tready;
        st_popped = p && !out_empty;
        st_got    = {out_data, out_keep, out_last};
        st_exp    = 'x;
        if (st_popped && sb.size() > 0) st_exp = sb.pop_front();
        @(posedge aclk);
        bad = 1'b0;
        if (st_acc) begin
            sb.push_back({d, k, l});
            sum = int'(m_acc) + $countones(k);
            if (sum > 65535) sum = 65535;
            if (l) begin
                m_last = 16'(sum);
                m_acc  = '0;
                m_pkt  = m_pkt + 16'd1;
                bad = !(k == 4'h1 || k == 4'h3 || k == 4'h7 || k == 4'hF);
            end else begin
                m_acc = 16'(sum);
                bad = (k != 4'hF);
            end
        end
        if (bad) m_err = 1'b1;
        else if (clr) m_err = 1'b0;
        #1;
    endtask

    task automatic idle();
        step(1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        int n;
        @(negedge aclk);
        s_tvalid = 1'b0; out_pop = 1'b0; err_clr = 1'b0;
        aresetn = 1'b0;
        repeat (2) @(negedge aclk);
        model_clear();
        aresetn = 1'b1;
        n = 0;
        while (!s_tready && n < 8) begin
            @(negedge aclk);
            #1;
            n++;
        end
        checks++;
        if (!s_tready) begin
            errors++;
            $display("FAIL reset_ready_timeout s_tready=%0b required 1", s_tready);
        end
    endtask

    task automatic test_reset();
        int n;
        aresetn = 1'b0;
        s_tvalid = 1'b1; s_tdata = 32'hDEAD_BEEF; s_tkeep = 4'hF; s_tlast = 1'b1;
        out_pop = 1'b0; err_clr = 1'b0;
        s_tstrb = '0; s_tid = '0; s_tdest = '0; s_tuser = '0;
        model_clear();
        repeat (3) @(negedge aclk);
        #1;
        checks++; if (s_tready !== 1'b0) begin errors++; $display("FAIL rst_tready got %0b exp 0", s_tready); end
        checks++; if (level !== 5'd0) begin errors++; $display("FAIL rst_level got %0d exp 0", level); end
        checks++; if (out_empty !== 1'b1) begin errors++; $display("FAIL rst_empty got %0b exp 1", out_empty); end
        checks++; if (pkt_count !== 16'd0) begin errors++; $display("FAIL rst_pkt got %0d exp 0", pkt_count); end
        checks++; if (last_pkt_bytes !== 16'd0) begin errors++; $display("FAIL rst_bytes got %0d exp 0", last_pkt_bytes); end
        checks++; if (keep_err !== 1'b0) begin errors++; $display("FAIL rst_err got %0b exp 0", keep_err); end
        s_tvalid = 1'b0;
        aresetn = 1'b1;
        #1;
        checks++; if (s_tready !== 1'b0) begin errors++; $display("FAIL rst_release_tready got %0b exp 0", s_tready); end
        n = 0;
        while (!s_tready && n < 8) begin
            @(negedge aclk);
            #1;
            n++;
        end
        checks++; if (s_tready !== 1'b1) begin errors++; $display("FAIL rst_ready_rise got %0b exp 1", s_tready); end
    endtask

    task automatic test_single_packet();
        step(1'b1, 32'h1111_0001, 4'hF, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h1111_0002, 4'hF, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h1111_0003, 4'h3, 1'b1, 1'b0, 1'b0);
        checks++; if (level !== 5'd3) begin errors++; $display("FAIL single_level got %0d exp 3", level); end
        checks++; if (pkt_count !== 16'd1) begin errors++; $display("FAIL single_pkt got %0d exp 1", pkt_count); end
        checks++; if (last_pkt_bytes !== 16'd10) begin errors++; $display("FAIL single_bytes got %0d exp 10", last_pkt_bytes); end
        checks++; if (keep_err !== 1'b0) begin errors++; $display("FAIL single_err got %0b exp 0", keep_err); end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0);
            checks++;
            if (!st_popped || st_got !== st_exp) begin
                errors++; $display("FAIL single_data got %h exp %h popped %0b", st_got, st_exp, st_popped);
            end
        end
        step(1'b0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (level !== 5'd0 || out_empty !== 1'b1) begin
            errors++; $display("FAIL empty_pop level %0d empty %0b exp 0/1", level, out_empty);
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 32'hA000_0000 + i, 4'hF, 1'b1, 1'b0, 1'b0);
            checks++; if (!st_acc) begin errors++; $display("FAIL fill_accept beat %0d got 0 exp 1", i); end
        end
        checks++; if (s_tready !== 1'b0) begin errors++; $display("FAIL fill_tready got %0b exp 0", s_tready); end
        checks++; if (level !== 5'd16) begin errors++; $display("FAIL fill_level got %0d exp 16", level); end
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 32'hA000_0010, 4'hF, 1'b1, 1'b0, 1'b0);
            checks++; if (st_acc) begin errors++; $display("FAIL fill_held got 1 exp 0"); end
        end
        step(1'b1, 32'hA000_0010, 4'hF, 1'b1, 1'b1, 1'b0);
        checks++;
        if (st_acc || !st_popped || st_got !== st_exp) begin
            errors++; $display("FAIL fill_pop acc %0b got %h exp %h", st_acc, st_got, st_exp);
        end
        step(1'b1, 32'hA000_0010, 4'hF, 1'b1, 1'b0, 1'b0);
        checks++; if (!st_acc) begin errors++; $display("FAIL fill_17th got 0 exp 1"); end
        checks++; if (level !== 5'd16) begin errors++; $display("FAIL fill_level2 got %0d exp 16", level); end
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0);
            checks++;
            if (!st_popped || st_got !== st_exp) begin
                errors++; $display("FAIL fill_data got %h exp %h", st_got, st_exp);
            end
        end
        checks++; if (out_empty !== 1'b1) begin errors++; $display("FAIL fill_drained got %0b exp 1", out_empty); end
        checks++; if (pkt_count !== m_pkt) begin errors++; $display("FAIL fill_pkt got %0d exp %0d", pkt_count, m_pkt); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 5; i++) step(1'b1, 32'hB000_0000 + i, 4'hF, 1'b0, 1'b0, 1'b0);
        for (int i = 5; i < 45; i++) begin
            step(1'b1, 32'hB000_0000 + i, 4'hF, (i == 44), 1'b1, 1'b0);
            checks++;
            if (!st_popped || st_got !== st_exp || level !== 5'd5) begin
                errors++; $display("FAIL b2b_data got %h exp %h level %0d exp 5", st_got, st_exp, level);
            end
        end
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0);
            checks++;
            if (!st_popped || st_got !== st_exp) begin
                errors++; $display("FAIL b2b_drain got %h exp %h", st_got, st_exp);
            end
        end
        checks++; if (last_pkt_bytes !== 16'd180) begin errors++; $display("FAIL b2b_bytes got %0d exp 180", last_pkt_bytes); end
    endtask

    task automatic test_keep_err();
        step(1'b1, 32'hC000_0000, 4'h7, 1'b0, 1'b1, 1'b0);
        checks++; if (keep_err !== 1'b1) begin errors++; $display("FAIL err_set got %0b exp 1", keep_err); end
        step(1'b1, 32'hC000_0001, 4'h5, 1'b1, 1'b1, 1'b1);
        checks++; if (keep_err !== 1'b1) begin errors++; $display("FAIL err_priority got %0b exp 1", keep_err); end
        step(1'b0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b1);
        checks++; if (keep_err !== 1'b0) begin errors++; $display("FAIL err_clear got %0b exp 0", keep_err); end
        step(1'b1, 32'hC000_0002, 4'h1, 1'b1, 1'b1, 1'b0);
        checks++; if (keep_err !== m_err) begin errors++; $display("FAIL err_legal_last got %0b exp %0b", keep_err, m_err); end
        checks++; if (last_pkt_bytes !== 16'd1) begin errors++; $display("FAIL err_bytes got %0d exp 1", last_pkt_bytes); end
        step(1'b0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid_packet();
        step(1'b1, 32'hD000_0000, 4'hF, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'hD000_0001, 4'hF, 1'b0, 1'b0, 1'b0);
        do_reset();
        step(1'b1, 32'hD000_0002, 4'h1, 1'b1, 1'b0, 1'b0);
        checks++; if (level !== 5'd1) begin errors++; $display("FAIL rmp_level got %0d exp 1", level); end
        checks++; if (pkt_count !== 16'd1) begin errors++; $display("FAIL rmp_pkt got %0d exp 1", pkt_count); end
        checks++; if (last_pkt_bytes !== 16'd1) begin errors++; $display("FAIL rmp_bytes got %0d exp 1", last_pkt_bytes); end
        step(1'b0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (!st_popped || st_got !== st_exp) begin
            errors++; $display("FAIL rmp_data got %h exp %h", st_got, st_exp);
        end
    endtask

    task automatic test_wrap_saturate();
        do_reset();
        for (int i = 0; i < 65536; i++) begin
            step(1'b1, 32'(i), 4'h1, 1'b1, 1'b1, 1'b0);
            if (st_popped) begin
                checks++;
                if (st_got !== st_exp) begin errors++; $display("FAIL wrap_data got %h exp %h", st_got, st_exp); end
            end
            if (i == 65534) begin
                checks++; if (pkt_count !== 16'hFFFF) begin errors++; $display("FAIL wrap_ffff got %h exp ffff", pkt_count); end
            end
        end
        checks++; if (pkt_count !== 16'h0000) begin errors++; $display("FAIL wrap_zero got %h exp 0000", pkt_count); end
        for (int i = 0; i < 20000; i++) begin
            step(1'b1, 32'hE000_0000 + i, 4'hF, (i == 19999), 1'b1, 1'b0);
        end
        checks++; if (last_pkt_bytes !== 16'hFFFF) begin errors++; $display("FAIL sat_bytes got %h exp ffff", last_pkt_bytes); end
        checks++; if (pkt_count !== 16'h0001) begin errors++; $display("FAIL sat_pkt got %h exp 0001", pkt_count); end
        checks++; if (level !== 5'(sb.size())) begin errors++; $display("FAIL sat_level got %0d exp %0d", level, sb.size()); end
        idle();
    endtask

    initial begin
        test_reset();
        test_single_packet();
        test_fill();
        test_back_to_back();
        test_keep_err();
        test_reset_mid_packet();
        test_wrap_saturate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
